// File: rtl/gh_round_lps_folded.sv
// gh_round_lps_folded: Streebog LPS round stage (L(P(S(x))) on 512 bits).
// One block in flight at a time. The L transform is folded over
// LANES_PER_CYCLE 64-bit lanes per cycle. There are valid/ready handshakes
// on both sides, and a tag that travels with each block.
module gh_round_lps_folded #(
    parameter int LANES_PER_CYCLE = 8,
    parameter int TAG_W           = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clken,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [511:0]     in_data,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [511:0]     out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int         N        = LANES_PER_CYCLE;
    localparam int         GROUPS   = 8 / N;
    localparam logic [2:0] LAST_GRP = 3'(GROUPS - 1);

    if (!(N == 1 || N == 2 || N == 4 || N == 8)) begin : g_bad_lanes
        $error("gh_round_lps_folded: LANES_PER_CYCLE must be 1, 2, 4 or 8");
    end

    localparam logic [7:0] PI [256] = '{
        8'hFC, 8'hEE, 8'hDD, 8'h11, 8'hCF, 8'h6E, 8'h31, 8'h16, 8'hFB, 8'hC4, 8'hFA, 8'hDA, 8'h23, 8'hC5, 8'h04, 8'h4D,
        8'hE9, 8'h77, 8'hF0, 8'hDB, 8'h93, 8'h2E, 8'h99, 8'hBA, 8'h17, 8'h36, 8'hF1, 8'hBB, 8'h14, 8'hCD, 8'h5F, 8'hC1,
        8'hF9, 8'h18, 8'h65, 8'h5A, 8'hE2, 8'h5C, 8'hEF, 8'h21, 8'h81, 8'h1C, 8'h3C, 8'h42, 8'h8B, 8'h01, 8'h8E, 8'h4F,
        8'h05, 8'h84, 8'h02, 8'hAE, 8'hE3, 8'h6A, 8'h8F, 8'hA0, 8'h06, 8'h0B, 8'hED, 8'h98, 8'h7F, 8'hD4, 8'hD3, 8'h1F,
        8'hEB, 8'h34, 8'h2C, 8'h51, 8'hEA, 8'hC8, 8'h48, 8'hAB, 8'hF2, 8'h2A, 8'h68, 8'hA2, 8'hFD, 8'h3A, 8'hCE, 8'hCC,
        8'hB5, 8'h70, 8'h0E, 8'h56, 8'h08, 8'h0C, 8'h76, 8'h12, 8'hBF, 8'h72, 8'h13, 8'h47, 8'h9C, 8'hB7, 8'h5D, 8'h87,
        8'h15, 8'hA1, 8'h96, 8'h29, 8'h10, 8'h7B, 8'h9A, 8'hC7, 8'hF3, 8'h91, 8'h78, 8'h6F, 8'h9D, 8'h9E, 8'hB2, 8'hB1,
        8'h32, 8'h75, 8'h19, 8'h3D, 8'hFF, 8'h35, 8'h8A, 8'h7E, 8'h6D, 8'h54, 8'hC6, 8'h80, 8'hC3, 8'hBD, 8'h0D, 8'h57,
        8'hDF, 8'hF5, 8'h24, 8'hA9, 8'h3E, 8'hA8, 8'h43, 8'hC9, 8'hD7, 8'h79, 8'hD6, 8'hF6, 8'h7C, 8'h22, 8'hB9, 8'h03,
        8'hE0, 8'h0F, 8'hEC, 8'hDE, 8'h7A, 8'h94, 8'hB0, 8'hBC, 8'hDC, 8'hE8, 8'h28, 8'h50, 8'h4E, 8'h33, 8'h0A, 8'h4A,
        8'hA7, 8'h97, 8'h60, 8'h73, 8'h1E, 8'h00, 8'h62, 8'h44, 8'h1A, 8'hB8, 8'h38, 8'h82, 8'h64, 8'h9F, 8'h26, 8'h41,
        8'hAD, 8'h45, 8'h46, 8'h92, 8'h27, 8'h5E, 8'h55, 8'h2F, 8'h8C, 8'hA3, 8'hA5, 8'h7D, 8'h69, 8'hD5, 8'h95, 8'h3B,
        8'h07, 8'h58, 8'hB3, 8'h40, 8'h86, 8'hAC, 8'h1D, 8'hF7, 8'h30, 8'h37, 8'h6B, 8'hE4, 8'h88, 8'hD9, 8'hE7, 8'h89,
        8'hE1, 8'h1B, 8'h83, 8'h49, 8'h4C, 8'h3F, 8'hF8, 8'hFE, 8'h8D, 8'h53, 8'hAA, 8'h90, 8'hCA, 8'hD8, 8'h85, 8'h61,
        8'h20, 8'h71, 8'h67, 8'hA4, 8'h2D, 8'h2B, 8'h09, 8'h5B, 8'hCB, 8'h9B, 8'h25, 8'hD0, 8'hBE, 8'hE5, 8'h6C, 8'h52,
        8'h59, 8'hA6, 8'h74, 8'hD2, 8'hE6, 8'hF4, 8'hB4, 8'hC0, 8'hD1, 8'h66, 8'hAF, 8'hC2, 8'h39, 8'h4B, 8'h63, 8'hB6
    };

    localparam logic [63:0] A_MAT [64] = '{
        64'h8e20faa72ba0b470, 64'h47107ddd9b505a38, 64'had08b0e0c3282d1c, 64'hd8045870ef14980e,
        64'h6c022c38f90a4c07, 64'h3601161cf205268d, 64'h1b8e0b0e798c13c8, 64'h83478b07b2468764,
        64'ha011d380818e8f40, 64'h5086e740ce47c920, 64'h2843fd2067adea10, 64'h14aff010bdd87508,
        64'h0ad97808d06cb404, 64'h05e23c0468365a02, 64'h8c711e02341b2d01, 64'h46b60f011a83988e,
        64'h90dab52a387ae76f, 64'h486dd4151c3dfdb9, 64'h24b86a840e90f0d2, 64'h125c354207487869,
        64'h092e94218d243cba, 64'h8a174a9ec8121e5d, 64'h4585254f64090fa0, 64'haccc9ca9328a8950,
        64'h9d4df05d5f661451, 64'hc0a878a0a1330aa6, 64'h60543c50de970553, 64'h302a1e286fc58ca7,
        64'h18150f14b9ec46dd, 64'h0c84890ad27623e0, 64'h0642ca05693b9f70, 64'h0321658cba93c138,
        64'h86275df09ce8aaa8, 64'h439da0784e745554, 64'hafc0503c273aa42a, 64'hd960281e9d1d5215,
        64'he230140fc0802984, 64'h71180a8960409a42, 64'hb60c05ca30204d21, 64'h5b068c651810a89e,
        64'h456c34887a3805b9, 64'hac361a443d1c8cd2, 64'h561b0d22900e4669, 64'h2b838811480723ba,
        64'h9bcf4486248d9f5d, 64'hc3e9224312c8c1a0, 64'heffa11af0964ee50, 64'hf97d86d98a327728,
        64'he4fa2054a80b329c, 64'h727d102a548b194e, 64'h39b008152acb8227, 64'h9258048415eb419d,
        64'h492c024284fbaec0, 64'haa16012142f35760, 64'h550b8e9e21f7a530, 64'ha48b474f9ef5dc18,
        64'h70a6a56e2440598e, 64'h3853dc371220a247, 64'h1ca76e95091051ad, 64'h0edd37c48a08a6d8,
        64'h07e095624504536c, 64'h8d70c431ac02a736, 64'hc83862965601dd1b, 64'h641c314b2b8ee083
    };

    typedef enum logic [1:0] {IDLE, SUB, LIN, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [2:0]       cnt;
    logic [511:0]     w;
    logic [511:0]     w_lin;
    logic [TAG_W-1:0] tag_q;

    // S then P in one step: output byte 8i+j takes the substituted input byte 8j+i
    function automatic logic [511:0] sub_perm(input logic [511:0] x);
        logic [511:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                r[(8*i+j)*8 +: 8] = PI[x[(8*j+i)*8 +: 8]];
            end
        end
        return r;
    endfunction

    // Linear map over GF(2): the MSB of the lane selects row 0 of A
    function automatic logic [63:0] lin_lane(input logic [63:0] v);
        logic [63:0] r;
        r = '0;
        for (int j = 0; j < 64; j++) begin
            if (v[63-j]) begin
                r = r ^ A_MAT[j];
            end
        end
        return r;
    endfunction

    // Apply L to the N lanes of the current group and leave the other lanes unchanged
    always_comb begin
        w_lin = w;
        for (int i = 0; i < N; i++) begin
            w_lin[(int'(cnt)*N + i)*64 +: 64] = lin_lane(w[(int'(cnt)*N + i)*64 +: 64]);
        end
    end

    // Next-state decode for the IDLE -> SUB -> LIN... -> DONE sequence
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = SUB;
            SUB:     state_nxt = LIN;
            LIN:     if (cnt == LAST_GRP) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register. It advances only on enabled edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (clken) begin
            state <= state_nxt;
        end
    end

    // Work register, group counter and captured tag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w     <= '0;
            cnt   <= '0;
            tag_q <= '0;
        end else if (clken) begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        w     <= in_data;
                        tag_q <= in_tag;
                    end
                end
                SUB: begin
                    w   <= sub_perm(w);
                    cnt <= '0;
                end
                LIN: begin
                    w <= w_lin;
                    if (cnt != LAST_GRP) cnt <= cnt + 3'd1;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out_data  = w;
    assign out_tag   = tag_q;

endmodule

// File: tb/tb_gh_round_lps_folded.sv
// Bench for gh_round_lps_folded: four instances (N = 1, 2, 4, 8) share clock,
// reset and data inputs. A behavioural LPS model built from byte arrays
// provides every expected value.
module tb_gh_round_lps_folded;

    localparam logic [7:0] PI_T [256] = '{
        8'hFC, 8'hEE, 8'hDD, 8'h11, 8'hCF, 8'h6E, 8'h31, 8'h16, 8'hFB, 8'hC4, 8'hFA, 8'hDA, 8'h23, 8'hC5, 8'h04, 8'h4D,
        8'hE9, 8'h77, 8'hF0, 8'hDB, 8'h93, 8'h2E, 8'h99, 8'hBA, 8'h17, 8'h36, 8'hF1, 8'hBB, 8'h14, 8'hCD, 8'h5F, 8'hC1,
        8'hF9, 8'h18, 8'h65, 8'h5A, 8'hE2, 8'h5C, 8'hEF, 8'h21, 8'h81, 8'h1C, 8'h3C, 8'h42, 8'h8B, 8'h01, 8'h8E, 8'h4F,
        8'h05, 8'h84, 8'h02, 8'hAE, 8'hE3, 8'h6A, 8'h8F, 8'hA0, 8'h06, 8'h0B, 8'hED, 8'h98, 8'h7F, 8'hD4, 8'hD3, 8'h1F,
        8'hEB, 8'h34, 8'h2C, 8'h51, 8'hEA, 8'hC8, 8'h48, 8'hAB, 8'hF2, 8'h2A, 8'h68, 8'hA2, 8'hFD, 8'h3A, 8'hCE, 8'hCC,
        8'hB5, 8'h70, 8'h0E, 8'h56, 8'h08, 8'h0C, 8'h76, 8'h12, 8'hBF, 8'h72, 8'h13, 8'h47, 8'h9C, 8'hB7, 8'h5D, 8'h87,
        8'h15, 8'hA1, 8'h96, 8'h29, 8'h10, 8'h7B, 8'h9A, 8'hC7, 8'hF3, 8'h91, 8'h78, 8'h6F, 8'h9D, 8'h9E, 8'hB2, 8'hB1,
        8'h32, 8'h75, 8'h19, 8'h3D, 8'hFF, 8'h35, 8'h8A, 8'h7E, 8'h6D, 8'h54, 8'hC6, 8'h80, 8'hC3, 8'hBD, 8'h0D, 8'h57,
        8'hDF, 8'hF5, 8'h24, 8'hA9, 8'h3E, 8'hA8, 8'h43, 8'hC9, 8'hD7, 8'h79, 8'hD6, 8'hF6, 8'h7C, 8'h22, 8'hB9, 8'h03,
        8'hE0, 8'h0F, 8'hEC, 8'hDE, 8'h7A, 8'h94, 8'hB0, 8'hBC, 8'hDC, 8'hE8, 8'h28, 8'h50, 8'h4E, 8'h33, 8'h0A, 8'h4A,
        8'hA7, 8'h97, 8'h60, 8'h73, 8'h1E, 8'h00, 8'h62, 8'h44, 8'h1A, 8'hB8, 8'h38, 8'h82, 8'h64, 8'h9F, 8'h26, 8'h41,
        8'hAD, 8'h45, 8'h46, 8'h92, 8'h27, 8'h5E, 8'h55, 8'h2F, 8'h8C, 8'hA3, 8'hA5, 8'h7D, 8'h69, 8'hD5, 8'h95, 8'h3B,
        8'h07, 8'h58, 8'hB3, 8'h40, 8'h86, 8'hAC, 8'h1D, 8'hF7, 8'h30, 8'h37, 8'h6B, 8'hE4, 8'h88, 8'hD9, 8'hE7, 8'h89,
        8'hE1, 8'h1B, 8'h83, 8'h49, 8'h4C, 8'h3F, 8'hF8, 8'hFE, 8'h8D, 8'h53, 8'hAA, 8'h90, 8'hCA, 8'hD8, 8'h85, 8'h61,
        8'h20, 8'h71, 8'h67, 8'hA4, 8'h2D, 8'h2B, 8'h09, 8'h5B, 8'hCB, 8'h9B, 8'h25, 8'hD0, 8'hBE, 8'hE5, 8'h6C, 8'h52,
        8'h59, 8'hA6, 8'h74, 8'hD2, 8'hE6, 8'hF4, 8'hB4, 8'hC0, 8'hD1, 8'h66, 8'hAF, 8'hC2, 8'h39, 8'h4B, 8'h63, 8'hB6
    };

    localparam logic [63:0] A_T [64] = '{
        64'h8e20faa72ba0b470, 64'h47107ddd9b505a38, 64'had08b0e0c3282d1c, 64'hd8045870ef14980e,
        64'h6c022c38f90a4c07, 64'h3601161cf205268d, 64'h1b8e0b0e798c13c8, 64'h83478b07b2468764,
        64'ha011d380818e8f40, 64'h5086e740ce47c920, 64'h2843fd2067adea10, 64'h14aff010bdd87508,
        64'h0ad97808d06cb404, 64'h05e23c0468365a02, 64'h8c711e02341b2d01, 64'h46b60f011a83988e,
        64'h90dab52a387ae76f, 64'h486dd4151c3dfdb9, 64'h24b86a840e90f0d2, 64'h125c354207487869,
        64'h092e94218d243cba, 64'h8a174a9ec8121e5d, 64'h4585254f64090fa0, 64'haccc9ca9328a8950,
        64'h9d4df05d5f661451, 64'hc0a878a0a1330aa6, 64'h60543c50de970553, 64'h302a1e286fc58ca7,
        64'h18150f14b9ec46dd, 64'h0c84890ad27623e0, 64'h0642ca05693b9f70, 64'h0321658cba93c138,
        64'h86275df09ce8aaa8, 64'h439da0784e745554, 64'hafc0503c273aa42a, 64'hd960281e9d1d5215,
        64'he230140fc0802984, 64'h71180a8960409a42, 64'hb60c05ca30204d21, 64'h5b068c651810a89e,
        64'h456c34887a3805b9, 64'hac361a443d1c8cd2, 64'h561b0d22900e4669, 64'h2b838811480723ba,
        64'h9bcf4486248d9f5d, 64'hc3e9224312c8c1a0, 64'heffa11af0964ee50, 64'hf97d86d98a327728,
        64'he4fa2054a80b329c, 64'h727d102a548b194e, 64'h39b008152acb8227, 64'h9258048415eb419d,
        64'h492c024284fbaec0, 64'haa16012142f35760, 64'h550b8e9e21f7a530, 64'ha48b474f9ef5dc18,
        64'h70a6a56e2440598e, 64'h3853dc371220a247, 64'h1ca76e95091051ad, 64'h0edd37c48a08a6d8,
        64'h07e095624504536c, 64'h8d70c431ac02a736, 64'hc83862965601dd1b, 64'h641c314b2b8ee083
    };

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         clken = 1'b1;
    logic         in_valid = 1'b0;
    logic [511:0] in_data = '0;
    logic [3:0]   in_tag = '0;
    logic         out_ready = 1'b0;
    int           sel = 0;

    logic         iv [4];
    logic         ir [4];
    logic         ov [4];
    logic         bz [4];
    logic [511:0] od [4];
    logic [3:0]   ot [4];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        assign iv[g] = in_valid && (sel == g);
        gh_round_lps_folded #(.LANES_PER_CYCLE(1 << g), .TAG_W(4)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .clken     (clken),
            .in_valid  (iv[g]),
            .in_ready  (ir[g]),
            .in_data   (in_data),
            .in_tag    (in_tag),
            .out_valid (ov[g]),
            .out_ready (out_ready),
            .out_data  (od[g]),
            .out_tag   (ot[g]),
            .busy      (bz[g])
        );
    end

    // Reference L on one 64-bit word: XOR the matrix rows picked by bits, MSB first
    function automatic logic [63:0] ref_l(input logic [63:0] v);
        logic [63:0] acc = '0;
        for (int j = 0; j < 64; j++) if (v[63-j]) acc ^= A_T[j];
        return acc;
    endfunction

    // Reference LPS: substitute bytes, transpose the 8x8 byte matrix, then apply L per lane
    function automatic logic [511:0] ref_lps(input logic [511:0] x);
        logic [7:0]   s [64];
        logic [7:0]   p [64];
        logic [511:0] r;
        for (int k = 0; k < 64; k++) s[k] = PI_T[x[8*k +: 8]];
        for (int row = 0; row < 8; row++)
            for (int col = 0; col < 8; col++) p[8*row + col] = s[8*col + row];
        for (int ln = 0; ln < 8; ln++) begin
            logic [63:0] lane;
            for (int b = 0; b < 8; b++) lane[8*b +: 8] = p[8*ln + b];
            r[64*ln +: 64] = ref_l(lane);
        end
        return r;
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int k = 0; k < 16; k++) r[32*k +: 32] = $urandom;
        return r;
    endfunction

    task automatic chk(input string name, input logic [511:0] obs, input logic [511:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a block and hold it until the selected instance takes it
    task automatic accept(input int s, input logic [511:0] d, input logic [3:0] t);
        int waited = 0;
        sel = s; in_data = d; in_tag = t; in_valid = 1'b1;
        while (!ir[s] && waited < 100) begin tick(); waited++; end
        chk("accept_wait", 512'(waited < 100), 512'd1);
        tick();
        in_valid = 1'b0;
        in_data  = rand512();
        in_tag   = 4'($urandom);
    endtask

    // Wait for out_valid after an accept, optionally freezing clken for 5 cycles
    task automatic collect(input int s, input logic [511:0] exp_d, input logic [3:0] exp_t,
                           input int exp_lat, input int stall_at);
        int lat = 1;
        while (!ov[s] && lat < 200) begin
            if (stall_at > 0 && lat == stall_at) clken = 1'b0;
            if (stall_at > 0 && lat == stall_at + 5) clken = 1'b1;
            tick();
            lat++;
        end
        clken = 1'b1;
        chk("latency", 512'(lat), 512'(exp_lat));
        chk("out_data", od[s], exp_d);
        chk("out_tag", 512'(ot[s]), 512'(exp_t));
    endtask

    // Hold out_ready low for dly cycles, then complete the output handshake
    task automatic release_out(input int s, input int dly, input logic [511:0] exp_d);
        out_ready = 1'b0;
        repeat (dly) tick();
        chk("held_data", od[s], exp_d);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("valid_drop", 512'(ov[s]), 512'd0);
    endtask

    initial begin
        logic [511:0] d;
        logic [511:0] e;
        logic [511:0] d2;
        logic [3:0]   t;
        int           n;

        // Reset state of every instance
        #2;
        for (int g = 0; g < 4; g++) begin
            chk("rst_out_valid", 512'(ov[g]), 512'd0);
            chk("rst_in_ready", 512'(ir[g]), 512'd1);
            chk("rst_busy", 512'(bz[g]), 512'd0);
            chk("rst_out_data", od[g], 512'd0);
            chk("rst_out_tag", 512'(ot[g]), 512'd0);
        end
        tick();
        rst_n = 1'b1;
        tick();

        // All-zero block on N=8: each lane is L of the all-pi[0] word
        accept(3, 512'd0, 4'h5);
        collect(3, ref_lps(512'd0), 4'h5, 3, 0);
        chk("zero_lanes", od[3], {8{ref_l(64'hFCFCFCFCFCFCFCFC)}});
        release_out(3, 0, ref_lps(512'd0));

        // Single set byte
        d = 512'h01;
        accept(3, d, 4'hA);
        collect(3, ref_lps(d), 4'hA, 3, 0);
        release_out(3, 1, ref_lps(d));
        accept(0, d, 4'h3);
        collect(0, ref_lps(d), 4'h3, 10, 0);
        release_out(0, 0, ref_lps(d));

        // Random blocks with random gaps on every fold factor
        for (int s = 0; s < 4; s++) begin
            n = 8 >> s;
            for (int k = 0; k < 1000; k++) begin
                d = rand512();
                t = 4'($urandom);
                repeat ($urandom_range(0, 2)) tick();
                accept(s, d, t);
                collect(s, ref_lps(d), t, 2 + n, 0);
                release_out(s, $urandom_range(0, 2), ref_lps(d));
            end
        end

        // Backpressure on N=8 with a second block waiting at the input
        d = rand512(); d2 = rand512();
        e = ref_lps(d);
        accept(3, d, 4'h9);
        collect(3, e, 4'h9, 3, 0);
        sel = 3; in_data = d2; in_tag = 4'h6; in_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            chk("bp_valid", 512'(ov[3]), 512'd1);
            chk("bp_data", od[3], e);
            chk("bp_tag", 512'(ot[3]), 512'h9);
            chk("bp_in_ready", 512'(ir[3]), 512'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_idle_ready", 512'(ir[3]), 512'd1);
        tick();
        chk("bp_taken", 512'(bz[3]), 512'd1);
        in_valid = 1'b0;
        in_data  = rand512();
        collect(3, ref_lps(d2), 4'h6, 3, 0);
        release_out(3, 0, ref_lps(d2));

        // clken low for 5 cycles while N=2 is in its second lane group
        d = rand512();
        accept(1, d, 4'hC);
        collect(1, ref_lps(d), 4'hC, 6 + 5, 3);
        release_out(1, 0, ref_lps(d));

        // Asynchronous reset mid-LIN on N=1, then a fresh block
        d = rand512();
        accept(0, d, 4'hE);
        repeat (4) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 512'(ov[0]), 512'd0);
        chk("arst_busy", 512'(bz[0]), 512'd0);
        chk("arst_in_ready", 512'(ir[0]), 512'd1);
        chk("arst_out_data", od[0], 512'd0);
        chk("arst_out_tag", 512'(ot[0]), 512'd0);
        tick();
        rst_n = 1'b1;
        d = rand512();
        accept(0, d, 4'h2);
        collect(0, ref_lps(d), 4'h2, 10, 0);
        release_out(0, 0, ref_lps(d));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Watchdog against a stuck handshake
    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
        $fatal(1, "watchdog");
    end

endmodule
